// File: rtl/instr_reg_scheduler_if.sv
// Handshake and bus bundle between two instruction sources, the scheduler, the
// instruction register and the issue consumer.
interface instr_reg_scheduler_if #(
    parameter int unsigned AW = 5
);
    logic               req0_valid;
    logic               req0_ready;
    logic [3:0]         req0_opcode;
    logic signed [31:0] req0_operand_a;
    logic signed [31:0] req0_operand_b;

    logic               req1_valid;
    logic               req1_ready;
    logic [3:0]         req1_opcode;
    logic signed [31:0] req1_operand_a;
    logic signed [31:0] req1_operand_b;

    logic               ir_load_en;
    logic [AW-1:0]      ir_write_pointer;
    logic [3:0]         ir_opcode;
    logic signed [31:0] ir_operand_a;
    logic signed [31:0] ir_operand_b;
    logic [AW-1:0]      ir_read_pointer;

    logic               issue_valid;
    logic               issue_ready;

    logic               flush;
    logic               drain;
    logic               resume;

    logic [AW:0]        count;
    logic               full;
    logic               empty;
    logic               drained;

    modport slave (
        input  req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
        input  req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
        input  issue_ready, flush, drain, resume,
        output req0_ready, req1_ready,
        output ir_load_en, ir_write_pointer, ir_opcode, ir_operand_a, ir_operand_b,
        output ir_read_pointer, issue_valid,
        output count, full, empty, drained
    );

    modport master (
        output req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
        output req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
        output issue_ready, flush, drain, resume,
        input  req0_ready, req1_ready,
        input  ir_load_en, ir_write_pointer, ir_opcode, ir_operand_a, ir_operand_b,
        input  ir_read_pointer, issue_valid,
        input  count, full, empty, drained
    );
endinterface

// File: rtl/instr_reg_scheduler.sv
// Shares the instruction register write port between two requesters (round-robin) and
// sequences head reads to one consumer, with a run/drain/pause quiesce FSM.
module instr_reg_scheduler #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    instr_reg_scheduler_if.slave   bus_io
);

    typedef enum logic [1:0] {StRun, StDrain, StPaused} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          rr_q, rr_d;

    logic full, empty, accept, pop, grant;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    // Round-robin only matters under contention; a lone requester always wins.
    assign grant = (bus_io.req0_valid && bus_io.req1_valid) ? rr_q : bus_io.req1_valid;

    // Ready depends on registered full only, so a same-cycle pop never frees a slot.
    assign accept = (state_q == StRun) && !full && !bus_io.flush &&
                    (bus_io.req0_valid || bus_io.req1_valid);
    assign pop    = !empty && bus_io.issue_ready;

    always_comb begin
        bus_io.req0_ready       = accept && !grant;
        bus_io.req1_ready       = accept && grant;
        bus_io.ir_load_en       = accept;
        bus_io.ir_write_pointer = wr_ptr_q;
        bus_io.ir_opcode        = '0;
        bus_io.ir_operand_a     = '0;
        bus_io.ir_operand_b     = '0;
        if (accept) begin
            if (grant) begin
                bus_io.ir_opcode    = bus_io.req1_opcode;
                bus_io.ir_operand_a = bus_io.req1_operand_a;
                bus_io.ir_operand_b = bus_io.req1_operand_b;
            end else begin
                bus_io.ir_opcode    = bus_io.req0_opcode;
                bus_io.ir_operand_a = bus_io.req0_operand_a;
                bus_io.ir_operand_b = bus_io.req0_operand_b;
            end
        end
        bus_io.ir_read_pointer = rd_ptr_q;
        bus_io.issue_valid     = !empty;
        bus_io.count           = count_q;
        bus_io.full            = full;
        bus_io.empty           = empty;
        bus_io.drained         = (state_q == StPaused);
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rr_d     = rr_q;

        if (bus_io.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            // The queue is empty after a flush, so a pending drain is complete.
            if (state_q == StDrain) begin
                state_d = StPaused;
            end
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                rr_d     = ~grant;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({accept, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase

            unique case (state_q)
                StRun: begin
                    if (bus_io.drain) begin
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    if (empty) begin
                        state_d = StPaused;
                    end
                end
                StPaused: begin
                    if (bus_io.resume) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StRun;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
        end
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (!reset_n) count_q <= (AW+1)'(DEPTH));
    assert property (@(posedge clk) disable iff (!reset_n)
                     (wr_ptr_q - rd_ptr_q) == count_q[AW-1:0]);
    assert property (@(posedge clk) disable iff (!reset_n)
                     !(bus_io.req0_ready && bus_io.req1_ready));
`endif

endmodule

// File: tb/tb_instr_reg_scheduler.sv
// Bench for instr_reg_scheduler: directed vector table, hand-written corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_instr_reg_scheduler;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int MRun    = 0;
    localparam int MDrain  = 1;
    localparam int MPaused = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    instr_reg_scheduler_if #(.AW(AW)) bus ();

    instr_reg_scheduler #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_io  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: queue contents, absolute pointers, mode and favoured requester.
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    ent_t mq[$];
    int   m_wr   = 0;
    int   m_rd   = 0;
    int   m_mode = MRun;
    int   m_rr   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_grant(output bit acc, output int g);
        g = (bus.req0_valid && bus.req1_valid) ? m_rr : (bus.req1_valid ? 1 : 0);
        acc = (m_mode == MRun) && (mq.size() < DEPTH) && !bus.flush &&
              (bus.req0_valid || bus.req1_valid);
    endtask

    task automatic model_check();
        bit   acc;
        int   g;
        ent_t e;
        model_grant(acc, g);
        e = '0;
        if (acc) begin
            e.op = g ? bus.req1_opcode    : bus.req0_opcode;
            e.a  = g ? bus.req1_operand_a : bus.req0_operand_a;
            e.b  = g ? bus.req1_operand_b : bus.req0_operand_b;
        end
        check("load_en", 32'(bus.ir_load_en), 32'(acc));
        check("ready0", 32'(bus.req0_ready), 32'(acc && g == 0));
        check("ready1", 32'(bus.req1_ready), 32'(acc && g == 1));
        check("wr_ptr", 32'(bus.ir_write_pointer), 32'(m_wr % DEPTH));
        check("ir_opcode", 32'(bus.ir_opcode), 32'(e.op));
        check("ir_operand_a", 32'(bus.ir_operand_a), e.a);
        check("ir_operand_b", 32'(bus.ir_operand_b), e.b);
        check("rd_ptr", 32'(bus.ir_read_pointer), 32'(m_rd % DEPTH));
        check("issue_valid", 32'(bus.issue_valid), 32'(mq.size() != 0));
        check("count", 32'(bus.count), 32'(mq.size()));
        check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
        check("empty", 32'(bus.empty), 32'(mq.size() == 0));
        check("drained", 32'(bus.drained), 32'(m_mode == MPaused));
    endtask

    task automatic model_update();
        bit   acc;
        int   g;
        int   n;
        ent_t e;
        n = mq.size();
        model_grant(acc, g);
        if (!reset_n) begin
            mq.delete();
            m_wr = 0; m_rd = 0; m_mode = MRun; m_rr = 0;
        end else if (bus.flush) begin
            mq.delete();
            m_wr = 0; m_rd = 0;
            if (m_mode == MDrain) m_mode = MPaused;
        end else begin
            if (n > 0 && bus.issue_ready) begin
                void'(mq.pop_front());
                m_rd = (m_rd + 1) % DEPTH;
            end
            if (acc) begin
                e.op = g ? bus.req1_opcode    : bus.req0_opcode;
                e.a  = g ? bus.req1_operand_a : bus.req0_operand_a;
                e.b  = g ? bus.req1_operand_b : bus.req0_operand_b;
                mq.push_back(e);
                m_wr = (m_wr + 1) % DEPTH;
                m_rr = 1 - g;
            end
            if (m_mode == MRun && bus.drain) m_mode = MDrain;
            else if (m_mode == MDrain && n == 0) m_mode = MPaused;
            else if (m_mode == MPaused && bus.resume) m_mode = MRun;
        end
    endtask

    task automatic settle();
        #1;
        model_check();
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_opcode = '0; bus.req1_opcode = '0;
        bus.req0_operand_a = '0; bus.req0_operand_b = '0;
        bus.req1_operand_a = '0; bus.req1_operand_b = '0;
        bus.issue_ready = 1'b0; bus.flush = 1'b0; bus.drain = 1'b0; bus.resume = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.req0_valid = 1'b1;
            bus.req0_opcode = 4'(i + 1);
            bus.req0_operand_a = 32'(i * 7 - 20);
            bus.req0_operand_b = 32'(-i);
            cyc();
        end
        bus.req0_valid = 1'b0;
    endtask

    typedef struct {
        bit         rst_n, v0, v1, rdy;
        logic [3:0] op0, op1;
        bit         exp_load, exp_r0, exp_r1;
        int         exp_wp, exp_cnt, exp_rp;
        bit         exp_iv;
        logic [3:0] exp_op;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 1, 0, 0, 4'h1, 4'h0, 1, 1, 0, 0, 0, 0, 0, 4'h1};
        tbl[1] = '{1, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 1, 1, 0, 1, 4'h0};
        tbl[2] = '{0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 1, 1, 0, 1, 4'h0};
        tbl[3] = '{1, 1, 1, 0, 4'h2, 4'h3, 1, 1, 0, 0, 0, 0, 0, 4'h2};
        tbl[4] = '{1, 1, 1, 0, 4'h2, 4'h3, 1, 0, 1, 1, 1, 0, 1, 4'h3};
        tbl[5] = '{1, 1, 1, 0, 4'h2, 4'h3, 1, 1, 0, 2, 2, 0, 1, 4'h2};
        tbl[6] = '{1, 1, 1, 0, 4'h2, 4'h3, 1, 0, 1, 3, 3, 0, 1, 4'h3};
        tbl[7] = '{1, 1, 1, 0, 4'h2, 4'h3, 1, 1, 0, 4, 4, 0, 1, 4'h2};
        tbl[8] = '{1, 1, 1, 0, 4'h2, 4'h3, 1, 0, 1, 5, 5, 0, 1, 4'h3};
        tbl[9] = '{1, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 6, 6, 0, 1, 4'h0};

        idle_inputs();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        settle();
        check("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_drained", 32'(bus.drained), 32'd0);
        tick();

        // Directed vector table: single write, then reset and 6 cycles of contention
        for (int i = 0; i < 10; i++) begin
            reset_n = tbl[i].rst_n;
            bus.req0_valid = tbl[i].v0; bus.req1_valid = tbl[i].v1;
            bus.req0_opcode = tbl[i].op0; bus.req1_opcode = tbl[i].op1;
            bus.req0_operand_a = 32'sd5; bus.req0_operand_b = 32'sd3;
            bus.req1_operand_a = -32'sd2; bus.req1_operand_b = 32'sd100;
            bus.issue_ready = tbl[i].rdy;
            #1;
            check($sformatf("vec%0d_load", i), 32'(bus.ir_load_en), 32'(tbl[i].exp_load));
            check($sformatf("vec%0d_r0", i), 32'(bus.req0_ready), 32'(tbl[i].exp_r0));
            check($sformatf("vec%0d_r1", i), 32'(bus.req1_ready), 32'(tbl[i].exp_r1));
            check($sformatf("vec%0d_wp", i), 32'(bus.ir_write_pointer), 32'(tbl[i].exp_wp));
            check($sformatf("vec%0d_cnt", i), 32'(bus.count), 32'(tbl[i].exp_cnt));
            check($sformatf("vec%0d_rp", i), 32'(bus.ir_read_pointer), 32'(tbl[i].exp_rp));
            check($sformatf("vec%0d_iv", i), 32'(bus.issue_valid), 32'(tbl[i].exp_iv));
            check($sformatf("vec%0d_op", i), 32'(bus.ir_opcode), 32'(tbl[i].exp_op));
            check($sformatf("vec%0d_a", i), 32'(bus.ir_operand_a),
                  32'(tbl[i].exp_load ? (tbl[i].exp_r1 ? -2 : 5) : 0));
            check($sformatf("vec%0d_b", i), 32'(bus.ir_operand_b),
                  32'(tbl[i].exp_load ? (tbl[i].exp_r1 ? 100 : 3) : 0));
            tick();
        end
        reset_n = 1'b1;

        // Fill to full, one pop, then a wrapped write at pointer 0
        do_reset();
        write_n(DEPTH);
        bus.req0_valid = 1'b1;
        settle();
        check("full_flag", 32'(bus.full), 32'd1);
        check("full_count", 32'(bus.count), 32'd32);
        check("full_ready0", 32'(bus.req0_ready), 32'd0);
        tick();
        bus.issue_ready = 1'b1;
        settle();
        check("full_pop_ready0", 32'(bus.req0_ready), 32'd0);
        tick();
        bus.issue_ready = 1'b0;
        settle();
        check("wrap_full", 32'(bus.full), 32'd0);
        check("wrap_ready0", 32'(bus.req0_ready), 32'd1);
        check("wrap_wptr", 32'(bus.ir_write_pointer), 32'd0);
        tick();
        bus.req0_valid = 1'b0;

        // Simultaneous accept and pop at count 3
        do_reset();
        write_n(3);
        bus.req0_valid = 1'b1; bus.issue_ready = 1'b1;
        settle();
        tick();
        bus.req0_valid = 1'b0; bus.issue_ready = 1'b0;
        settle();
        check("accpop_count", 32'(bus.count), 32'd3);
        check("accpop_wptr", 32'(bus.ir_write_pointer), 32'd4);
        check("accpop_rptr", 32'(bus.ir_read_pointer), 32'd1);
        tick();

        // Drain at count 4, drained after empty, then resume
        do_reset();
        write_n(4);
        bus.drain = 1'b1; bus.issue_ready = 1'b1;
        cyc();
        bus.drain = 1'b0; bus.req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("drain_ready0", 32'(bus.req0_ready), 32'd0);
            tick();
        end
        settle();
        check("drain_count0", 32'(bus.count), 32'd0);
        check("drain_not_yet", 32'(bus.drained), 32'd0);
        tick();
        settle();
        check("paused_drained", 32'(bus.drained), 32'd1);
        check("paused_ready0", 32'(bus.req0_ready), 32'd0);
        tick();
        bus.resume = 1'b1;
        cyc();
        bus.resume = 1'b0;
        settle();
        check("resume_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0; bus.issue_ready = 1'b0;

        // Flush at count 10 with a request pending
        do_reset();
        write_n(10);
        bus.flush = 1'b1; bus.req0_valid = 1'b1;
        settle();
        check("flush_ready0", 32'(bus.req0_ready), 32'd0);
        check("flush_load", 32'(bus.ir_load_en), 32'd0);
        tick();
        bus.flush = 1'b0; bus.req0_valid = 1'b0;
        settle();
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_wptr", 32'(bus.ir_write_pointer), 32'd0);
        check("flush_rptr", 32'(bus.ir_read_pointer), 32'd0);
        check("flush_empty", 32'(bus.empty), 32'd1);
        tick();

        // Reset in the middle of a drain
        write_n(5);
        bus.drain = 1'b1;
        cyc();
        bus.drain = 1'b0; bus.req0_valid = 1'b1;
        settle();
        check("middrain_ready0", 32'(bus.req0_ready), 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        bus.req0_valid = 1'b1;
        settle();
        check("rst_drain_count", 32'(bus.count), 32'd0);
        check("rst_drain_empty", 32'(bus.empty), 32'd1);
        check("rst_drain_drained", 32'(bus.drained), 32'd0);
        check("rst_drain_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;

        // Random traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            int seg;
            int pv;
            int pr;
            seg = (c / 100) % 3;
            pv = (seg == 0) ? 90 : ((seg == 1) ? 50 : 25);
            pr = (seg == 0) ? 10 : ((seg == 1) ? 50 : 85);
            reset_n = ($urandom_range(0, 299) != 0);
            bus.req0_valid = reset_n && ($urandom_range(0, 99) < pv);
            bus.req1_valid = reset_n && ($urandom_range(0, 99) < pv);
            bus.req0_opcode = 4'($urandom);
            bus.req1_opcode = 4'($urandom);
            bus.req0_operand_a = $urandom; bus.req0_operand_b = $urandom;
            bus.req1_operand_a = $urandom; bus.req1_operand_b = $urandom;
            bus.issue_ready = ($urandom_range(0, 99) < pr);
            bus.flush  = ($urandom_range(0, 59) == 0);
            bus.drain  = ($urandom_range(0, 39) == 0);
            bus.resume = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
